// File: rtl/reference_ramp.sv
// Setpoint slew-rate limiter ahead of the PID reference input: moves the output
// toward the latched target by at most `step` LSB per prescaled tick.
module reference_ramp #(
  parameter int DATA_WIDTH    = 16,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic signed [DATA_WIDTH-1:0]    target_data,
  input  logic                            target_valid,
  output logic                            target_ready,
  input  logic                            load_now,
  input  logic        [DATA_WIDTH-1:0]    step,
  input  logic        [DIVIDER_WIDTH-1:0] tick_divider,
  output logic signed [DATA_WIDTH-1:0]    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            ramp_active,
  output logic                            at_target
);

  typedef enum logic {HOLD, RAMP} state_t;

  state_t                          state_q, state_d;
  logic signed [DATA_WIDTH-1:0]    target_q, target_d;
  logic signed [DATA_WIDTH-1:0]    current_q, current_d;
  logic signed [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            ready_q;
  logic        [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
  logic                            tick;
  logic                            accept;

  // Difference is taken one bit wider so full-scale swings never overflow;
  // the step is applied only when it cannot overshoot, so no wrap is possible.
  function automatic logic signed [DATA_WIDTH-1:0] slew_update(
    input logic signed [DATA_WIDTH-1:0] cur,
    input logic signed [DATA_WIDTH-1:0] tgt,
    input logic        [DATA_WIDTH-1:0] stp
  );
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] mag;
    logic signed [DATA_WIDTH:0] stp_w;
    logic signed [DATA_WIDTH:0] nxt;
    diff  = {tgt[DATA_WIDTH-1], tgt} - {cur[DATA_WIDTH-1], cur};
    mag   = (diff < 0) ? -diff : diff;
    stp_w = $signed({1'b0, stp});
    if (mag <= stp_w) begin
      nxt = {tgt[DATA_WIDTH-1], tgt};
    end else if (diff > 0) begin
      nxt = {cur[DATA_WIDTH-1], cur} + stp_w;
    end else begin
      nxt = {cur[DATA_WIDTH-1], cur} - stp_w;
    end
    return nxt[DATA_WIDTH-1:0];
  endfunction

  assign accept = target_valid & ready_q;
  // >= rather than == keeps the prescaler from running the long way round if
  // tick_divider is lowered below the current count.
  assign tick   = enable & (cnt_q >= tick_divider);

  always_comb begin
    cnt_d       = cnt_q;
    target_d    = target_q;
    current_d   = current_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;

    if (!enable)   cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;

    if (accept) target_d = target_data;

    // A tick uses the target latched before this edge; load_now takes the
    // freshest target and overrides any coincident tick.
    if (load_now) begin
      current_d   = target_d;
      out_data_d  = target_d;
      out_valid_d = 1'b1;
    end else if (tick) begin
      current_d   = slew_update(current_q, target_q, step);
      out_data_d  = current_d;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    state_d = (current_d != target_d) ? RAMP : HOLD;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HOLD;
      target_q    <= '0;
      current_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      current_q   <= current_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= 1'b1;
      cnt_q       <= cnt_d;
    end
  end

  assign target_ready = ready_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign ramp_active  = (state_q == RAMP);
  assign at_target    = (state_q == HOLD);

endmodule

// File: tb/tb_reference_ramp.sv
// Self-checking bench for reference_ramp: spec-derived vector table, directed
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_reference_ramp;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] target_data;
  logic               target_valid;
  logic               target_ready;
  logic               load_now;
  logic        [15:0] step;
  logic        [15:0] tick_divider;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               ramp_active;
  logic               at_target;

  int checks = 0;
  int errors = 0;

  // Reference model state in plain integers.
  int m_tgt, m_cur, m_cnt, m_od;
  bit m_ov, m_rdy;

  reference_ramp #(.DATA_WIDTH(16), .DIVIDER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .target_data(target_data), .target_valid(target_valid),
    .target_ready(target_ready), .load_now(load_now), .step(step),
    .tick_divider(tick_divider), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ramp_active(ramp_active), .at_target(at_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tgt = 0; m_cur = 0; m_cnt = 0; m_od = 0; m_ov = 0; m_rdy = 0;
  endtask

  task automatic model_cycle(input bit en, input bit tv, input int td,
                             input bit ld, input int stp, input int div,
                             input bit ordy);
    int  newt, d;
    bit  tk;
    newt = (tv && m_rdy) ? td : m_tgt;
    tk   = en && (m_cnt == div);
    if (!en)     m_cnt = 0;
    else if (tk) m_cnt = 0;
    else         m_cnt = m_cnt + 1;
    if (ld) begin
      m_cur = newt; m_od = m_cur; m_ov = 1;
    end else if (tk) begin
      d = m_tgt - m_cur;
      if (d > stp)       m_cur = m_cur + stp;
      else if (d < -stp) m_cur = m_cur - stp;
      else               m_cur = m_tgt;
      m_od = m_cur; m_ov = 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    m_tgt = newt;
    m_rdy = 1;
  endtask

  task automatic cmp_model();
    chk("out_valid",    int'(out_valid),    int'(m_ov));
    chk("out_data",     int'(out_data),     m_od);
    chk("ramp_active",  int'(ramp_active),  int'(m_cur != m_tgt));
    chk("at_target",    int'(at_target),    int'(m_cur == m_tgt));
    chk("target_ready", int'(target_ready), int'(m_rdy));
  endtask

  // Drive one cycle of inputs, step the model, sample 1 time unit after the edge.
  task automatic cyc(input bit en, input bit tv, input int td, input bit ld,
                     input int stp, input int div, input bit ordy);
    logic [31:0] tdv;
    tdv          = td;
    enable       = en;
    target_valid = tv;
    target_data  = tdv[15:0];
    load_now     = ld;
    step         = 16'(stp);
    tick_divider = 16'(div);
    out_ready    = ordy;
    model_cycle(en, tv, td, ld, stp, div, ordy);
    @(posedge clock);
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit en; bit tv; int td; bit ld; int stp; int div; bit ordy;
    bit exp_ov; int exp_od; bit exp_at; bit exp_ramp;
  } vec_t;

  vec_t vecs[7];
  int   pulses, last_pulse;

  initial begin
    // Target 1000, step 300, tick every cycle: 300, 600, 900, 1000, 1000.
    vecs[0] = '{0, 1, 1000, 0, 300, 0, 1,  0,    0, 0, 1};
    vecs[1] = '{1, 0,    0, 0, 300, 0, 1,  1,  300, 0, 1};
    vecs[2] = '{1, 0,    0, 0, 300, 0, 1,  1,  600, 0, 1};
    vecs[3] = '{1, 0,    0, 0, 300, 0, 1,  1,  900, 0, 1};
    vecs[4] = '{1, 0,    0, 0, 300, 0, 1,  1, 1000, 1, 0};
    vecs[5] = '{1, 0,    0, 0, 300, 0, 1,  1, 1000, 1, 0};
    vecs[6] = '{0, 0,    0, 0, 300, 0, 1,  0, 1000, 1, 0};

    reset = 1'b0; enable = 0; target_valid = 0; target_data = '0;
    load_now = 0; step = '0; tick_divider = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst out_valid",    int'(out_valid),    0);
    chk("rst out_data",     int'(out_data),     0);
    chk("rst at_target",    int'(at_target),    1);
    chk("rst ramp_active",  int'(ramp_active),  0);
    chk("rst target_ready", int'(target_ready), 0);
    #3 reset = 1'b1;

    // Idle HOLD: one zero-valued sample every 4 clocks.
    pulses = 0; last_pulse = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 0, 0, 100, 3, 1);
      if (out_valid) begin
        pulses++;
        last_pulse = i;
        chk("idle sample value", int'(out_data), 0);
      end
      chk("idle at_target", int'(at_target), 1);
    end
    chk("idle pulse count", pulses, 3);
    chk("idle last pulse cycle", last_pulse, 12);

    cyc(0, 0, 0, 0, 300, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].en, vecs[i].tv, vecs[i].td, vecs[i].ld, vecs[i].stp,
          vecs[i].div, vecs[i].ordy);
      chk($sformatf("vec%0d out_valid", i),   int'(out_valid),   int'(vecs[i].exp_ov));
      chk($sformatf("vec%0d out_data", i),    int'(out_data),    vecs[i].exp_od);
      chk($sformatf("vec%0d at_target", i),   int'(at_target),   int'(vecs[i].exp_at));
      chk($sformatf("vec%0d ramp_active", i), int'(ramp_active), int'(vecs[i].exp_ramp));
    end

    // Full-scale swing both ways in a single tick, no wrap.
    cyc(0, 1, 32767, 1, 65535, 0, 1);
    chk("load 32767", int'(out_data), 32767);
    cyc(0, 1, -32768, 0, 65535, 0, 1);
    cyc(1, 0, 0, 0, 65535, 0, 1);
    chk("swing to min", int'(out_data), -32768);
    chk("swing to min at_target", int'(at_target), 1);
    cyc(0, 1, 32767, 0, 65535, 0, 1);
    cyc(1, 0, 0, 0, 65535, 0, 1);
    chk("swing to max", int'(out_data), 32767);

    // Back-pressure: samples are overwritten, never queued, ramp keeps going.
    cyc(0, 1, 0, 1, 50, 0, 1);
    cyc(0, 1, 500, 0, 50, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, 0, 50, 0, 0);
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp out_data", int'(out_data), 50 * k);
    end
    cyc(0, 0, 0, 0, 50, 0, 1);
    chk("bp drained", int'(out_valid), 0);
    chk("bp final data", int'(out_data), 500);

    // load_now with a coincident tick and a new target.
    cyc(0, 1, 3000, 0, 10, 0, 1);
    cyc(1, 0, 0, 0, 10, 0, 1);
    cyc(1, 1, -2000, 1, 10, 0, 1);
    chk("load out_data", int'(out_data), -2000);
    chk("load out_valid", int'(out_valid), 1);
    chk("load at_target", int'(at_target), 1);
    cyc(0, 0, 0, 0, 10, 0, 1);
    chk("load no intermediate", int'(out_data), -2000);

    // Asynchronous reset mid-ramp, between clock edges.
    cyc(0, 1, 0, 1, 100, 0, 1);
    cyc(0, 1, 1000, 0, 100, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 100, 0, 1);
    chk("pre-reset current", int'(out_data), 400);
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("async out_data", int'(out_data), 0);
    chk("async out_valid", int'(out_valid), 0);
    chk("async at_target", int'(at_target), 1);
    chk("async ramp_active", int'(ramp_active), 0);
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 100, 0, 1);
      chk("post-reset hold", int'(out_data), 0);
    end

    // Randomized traffic against the model.
    for (int seg = 0; seg < 8; seg++) begin
      int div, stp, sel;
      div = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      stp = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 20) :
            (sel == 2) ? $urandom_range(100, 5000) : 65535;
      cyc(0, 0, 0, 0, stp, div, 1);
      for (int c = 0; c < 50; c++) begin
        logic signed [15:0] r;
        r = 16'($urandom);
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, int'(r),
            $urandom_range(0, 19) == 0, stp, div, $urandom_range(0, 1) == 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reference_ramp.md
Name: reference_ramp

Overview:
- Setpoint slew-rate limiter that sits directly upstream of the PID reference input.
- Accepts step changes of the target setpoint.
- Emits a reference stream that moves toward the target by at most `step` LSB per update tick.
- Produces one output sample per tick, giving the PID a steady sample rate.

Parameters:
- DATA_WIDTH, 16, width of target/output samples (signed two's complement).
- DIVIDER_WIDTH, 16, width of the tick prescaler counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  ramp run enable.
- target_data  in  DATA_WIDTH  signed target setpoint.
- target_valid  in  1  target handshake valid.
- target_ready  out  1  target handshake ready.
- load_now  in  1  one-cycle pulse: current value jumps to the latched target without ramping.
- step  in  DATA_WIDTH  unsigned max change per tick.
- tick_divider  in  DIVIDER_WIDTH  tick period minus one, in clock cycles.
- out_data  out  DATA_WIDTH  signed ramped reference, to the PID reference stream.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- ramp_active  out  1  high while current != target.
- at_target  out  1  high while current == target.

Behaviour:
- Reset (asynchronous, active-low). All state clears immediately, including mid-ramp:
  - target = 0, current = 0, tick counter = 0, state = HOLD
  - out_data = 0, out_valid = 0
  - target_ready = 0, ramp_active = 0, at_target = 1
- target_ready goes high the first clock after reset deasserts and stays high. The target is latched on any cycle with target_valid & target_ready.
- Tick generation:
  - While enable = 1, the counter increments each clock. At count == tick_divider it wraps to 0 and generates a one-cycle tick.
  - tick_divider = 0 gives a tick every cycle.
  - enable = 0 holds the counter at 0 and produces no ticks. Current is frozen and out_valid is unaffected.
- State machine, with states HOLD (current == target) and RAMP (current != target):
  - HOLD -> RAMP on the cycle after a target differs from current.
  - RAMP -> HOLD when an update makes current == target.
  - ramp_active = (state == RAMP); at_target = (state == HOLD). Both are registered.
- Update on tick:
  - Compute diff = target - current in DATA_WIDTH+1 bits signed; no overflow for any pair.
  - If |diff| <= step, current = target.
  - Else current = current + step (diff > 0) or current - step (diff < 0).
  - step = 0 means current never moves, even with diff != 0.
  - No overshoot and no wrap-around: the full range -2^(DW-1) to 2^(DW-1)-1 is reachable at both ends.
- Simultaneous events:
  - A target accept and a tick on the same edge: the tick uses the previously latched target; the new target applies from the next tick.
  - load_now: current = target (the latched value, or the one being accepted that same cycle) at the next edge. A coincident tick is ignored. out_valid is asserted and the state goes to HOLD.
- Output handshake (axi_stream semantics):
  - Latency: out_data/out_valid update one clock after the tick; out_valid = 1 with out_data = new current.
  - out_valid stays high until a cycle with out_ready = 1, then drops the next cycle unless another tick coincides.
  - If a new tick arrives while a sample is still pending, out_data is overwritten with the newer value and out_valid stays high. Samples are dropped, never queued; the ramp never stalls on back-pressure.
  - A tick is issued in HOLD as well, so the PID sees one sample per tick period indefinitely.
- The ramp is not gated by out_ready.

Test Plan:
- Reset, tick_divider=3, step=100, enable=1, no target -> out_valid pulses every 4 clocks with out_data=0; at_target=1.
- Target 1000 accepted, step=300, tick_divider=0, out_ready=1:
  - out_data sequence 300, 600, 900, 1000, 1000
  - ramp_active high for exactly 4 ticks
  - at_target rises after the sample of value 1000
- Target -32768 from current 32767, step=65535 -> a single tick lands exactly on -32768, no wrap to a positive value; target back to 32767 -> single tick to 32767.
- out_ready=0 for 10 ticks during a ramp 0 -> 500 with step=50 -> out_valid held high, out_data tracks 50, 100, ... 500; the first accepted sample after out_ready=1 is 500.
- load_now pulsed with target=-2000 in the same cycle as a tick -> next cycle out_data=-2000, out_valid=1, at_target=1, no intermediate sample.
- Reset asserted asynchronously mid-ramp (current=400, target=1000), with no clock edge -> outputs are 0 and at_target=1 immediately; after release the ramp restarts from 0 with target 0.
